cambus_merlin_tx: RTL and testbench

// - Merlin camera-bus transmitter/emulator. Pulls 12-bit pixels from a clk-domain stream and drives a

---
 rtl/cambus_merlin_tx.sv | 186 ++++++++++++++++++
 tb/tb_cambus_merlin_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cambus_merlin_tx.sv
// Merlin camera-bus transmitter: pulls 12-bit pixels from a clk-domain stream
// and drives cam_clk/cam_pixel/cam_hsync/cam_vsync with Merlin framing.
// Optional internal test pattern enabled by defining CAMBUS_TX_TESTPAT_EN.
// Timing: a tick is the clk cycle with div_cnt==0 (cam_clk low phase start);
// in_ready is high during the tick cycle of each visible position and the bus
// registers load the new position at the edge closing that tick cycle.
module cambus_merlin_tx #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_ACTIVE  = 320,
  parameter int unsigned H_TOTAL   = 400,
  parameter int unsigned HSYNC_LEN = 16,
  parameter int unsigned V_ACTIVE  = 256,
  parameter int unsigned V_TOTAL   = 262,
  parameter int unsigned VSYNC_LEN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        testpat_sel,
  input  logic [11:0] in_pixel,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        cam_clk,
  output logic [11:0] cam_pixel,
  output logic        cam_hsync,
  output logic        cam_vsync,
  output logic        underflow,
  output logic        sof_err,
  output logic [15:0] frame_count
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned H_W   = $clog2(H_TOTAL);
  localparam int unsigned V_W   = $clog2(V_TOTAL);
  localparam int unsigned PIX_W = 12;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [H_W-1:0]   hcount, hcount_nxt, adv_h;
  logic [V_W-1:0]   vcount, vcount_nxt, adv_v;
  logic             tick, pre_tick, frame_last, adv_vis, first_pos;
  logic             tp_active;
  logic             cam_clk_nxt, hsync_nxt, vsync_nxt, ready_nxt;
  logic             underflow_nxt, sof_err_nxt;
  logic [PIX_W-1:0] pixel_nxt;
  logic [15:0]      frame_count_nxt;

  // Free-running divider and registered cam_clk phase
  always_comb begin
    div_nxt     = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
    cam_clk_nxt = (div_nxt >= DIV_W'(CLK_DIV / 2));
    tick        = (div_cnt == '0);
    pre_tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  end

  // Position that the next tick will drive, and its classification
  always_comb begin
    frame_last = (hcount == H_W'(H_TOTAL - 1)) && (vcount == V_W'(V_TOTAL - 1));
    adv_h      = hcount + H_W'(1);
    adv_v      = vcount;
    if (hcount == H_W'(H_TOTAL - 1)) begin
      adv_h = '0;
      adv_v = (vcount == V_W'(V_TOTAL - 1)) ? '0 : vcount + V_W'(1);
    end
    adv_vis   = (adv_v >= V_W'(1)) && (adv_v <= V_W'(V_ACTIVE)) &&
                (adv_h >= H_W'(2)) && (adv_h <= H_W'(H_ACTIVE + 1));
    first_pos = (adv_h == H_W'(2)) && (adv_v == V_W'(1));
  end

`ifdef CAMBUS_TX_TESTPAT_EN
  logic             tp_mode, frame_start;
  logic [PIX_W-1:0] tp_pixel;

  // Pattern value for the upcoming position; mode latched at each frame start
  always_comb begin
    tp_pixel    = PIX_W'(adv_h - H_W'(2)) + PIX_W'(adv_v - V_W'(1)) +
                  PIX_W'(frame_count[7:0]);
    frame_start = tick && en && ((state == IDLE) || frame_last);
    tp_active   = tp_mode;
  end

  // Test-pattern mode register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           tp_mode <= 1'b0;
    else if (frame_start) tp_mode <= testpat_sel;
  end
`else
  logic unused_testpat;
  assign unused_testpat = testpat_sel;
  assign tp_active      = 1'b0;
`endif

  // Next-state and next-output logic; bus outputs hold between ticks
  always_comb begin
    state_nxt       = state;
    hcount_nxt      = hcount;
    vcount_nxt      = vcount;
    pixel_nxt       = cam_pixel;
    hsync_nxt       = cam_hsync;
    vsync_nxt       = cam_vsync;
    frame_count_nxt = frame_count;
    underflow_nxt   = 1'b0;
    sof_err_nxt     = 1'b0;
    ready_nxt       = pre_tick && (state == RUN) && adv_vis && !tp_active;
    if (tick) begin
      case (state)
        IDLE: begin
          pixel_nxt = '0;
          hsync_nxt = 1'b0;
          vsync_nxt = 1'b0;
          if (en) begin
            state_nxt  = RUN;
            hcount_nxt = '0;
            vcount_nxt = '0;
            hsync_nxt  = 1'b1;
            vsync_nxt  = 1'b1;
          end
        end
        RUN: begin
          if (frame_last) frame_count_nxt = frame_count + 16'd1;
          if (frame_last && !en) begin
            state_nxt  = IDLE;
            hcount_nxt = '0;
            vcount_nxt = '0;
            pixel_nxt  = '0;
            hsync_nxt  = 1'b0;
            vsync_nxt  = 1'b0;
          end else begin
            hcount_nxt = adv_h;
            vcount_nxt = adv_v;
            hsync_nxt  = (adv_h < H_W'(HSYNC_LEN));
            vsync_nxt  = (adv_v < V_W'(VSYNC_LEN));
            pixel_nxt  = '0;
            if (in_ready) begin
              if (in_valid) begin
                pixel_nxt   = in_pixel;
                sof_err_nxt = (in_sof != first_pos);
              end else begin
                underflow_nxt = 1'b1;
              end
            end
`ifdef CAMBUS_TX_TESTPAT_EN
            if (tp_mode && adv_vis) pixel_nxt = tp_pixel;
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      hcount      <= '0;
      vcount      <= '0;
      cam_clk     <= 1'b0;
      cam_pixel   <= '0;
      cam_hsync   <= 1'b0;
      cam_vsync   <= 1'b0;
      in_ready    <= 1'b0;
      underflow   <= 1'b0;
      sof_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_nxt;
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      cam_clk     <= cam_clk_nxt;
      cam_pixel   <= pixel_nxt;
      cam_hsync   <= hsync_nxt;
      cam_vsync   <= vsync_nxt;
      in_ready    <= ready_nxt;
      underflow   <= underflow_nxt;
      sof_err     <= sof_err_nxt;
      frame_count <= frame_count_nxt;
    end
  end

endmodule

// File: tb/tb_cambus_merlin_tx.sv
// Self-checking bench for cambus_merlin_tx with a reduced frame geometry.
// The reference model tracks a linear position index within the frame.
module tb_cambus_merlin_tx;

  localparam int CLK_DIV   = 4;
  localparam int H_ACTIVE  = 8;
  localparam int H_TOTAL   = 14;
  localparam int HSYNC_LEN = 3;
  localparam int V_ACTIVE  = 5;
  localparam int V_TOTAL   = 8;
  localparam int VSYNC_LEN = 2;
  localparam int FRAME_LEN = H_TOTAL * V_TOTAL;
  localparam int FRAME_CLK = FRAME_LEN * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        testpat_sel = 1'b0;
  logic [11:0] in_pixel = '0;
  logic        in_sof = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, cam_clk, cam_hsync, cam_vsync, underflow, sof_err;
  logic [11:0] cam_pixel;
  logic [15:0] frame_count;

  cambus_merlin_tx #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .HSYNC_LEN(HSYNC_LEN), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .VSYNC_LEN(VSYNC_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .testpat_sel(testpat_sel),
    .in_pixel(in_pixel), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .cam_clk(cam_clk), .cam_pixel(cam_pixel),
    .cam_hsync(cam_hsync), .cam_vsync(cam_vsync), .underflow(underflow),
    .sof_err(sof_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          m_cyc, m_t, m_pops;
  bit          m_run, m_tp;
  logic [15:0] m_fc;
  logic [11:0] e_pix, src_val;
  int          valid_mode, sof_mode;
  int          pop_seen, uf_seen, se_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_vis(input int t);
    int h, v;
    h = t % H_TOTAL;
    v = t / H_TOTAL;
    return (v >= 1) && (v <= V_ACTIVE) && (h >= 2) && (h < H_ACTIVE + 2);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_t = 0; m_pops = 0; m_run = 0; m_tp = 0; m_fc = '0; e_pix = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clk"}, cam_clk, 0);
    check({tag, "_pix"}, cam_pixel, 0);
    check({tag, "_hs"}, cam_hsync, 0);
    check({tag, "_vs"}, cam_vsync, 0);
    check({tag, "_rdy"}, in_ready, 0);
    check({tag, "_uf"}, underflow, 0);
    check({tag, "_se"}, sof_err, 0);
    check({tag, "_fc"}, frame_count, 0);
  endtask

  // one clk cycle: drive inputs, predict, clock, compare
  task automatic step();
    int ph, nt, h, v;
    bit rdy, first, valid_in, sof_in, en_in, tp_in, e_uf, e_se;
    logic [11:0] pix_in;
    ph    = m_cyc % CLK_DIV;
    nt    = (m_t == FRAME_LEN - 1) ? 0 : m_t + 1;
    h     = nt % H_TOTAL;
    v     = nt / H_TOTAL;
    first = (h == 2) && (v == 1);
    rdy   = m_run && (ph == 0) && is_vis(nt) && !m_tp;
    case (valid_mode)
      0:       in_valid = 1'b1;
      1:       in_valid = ($urandom_range(0, 3) != 0);
      default: in_valid = !((v == 3) && (h - 2 >= 2) && (h - 2 <= 4));
    endcase
    in_pixel = src_val;
    in_sof   = (sof_mode == 0) ? first : (m_pops == 5);
    check("in_ready", in_ready, rdy);
    if (in_ready === 1'b1 && in_valid) pop_seen++;
    valid_in = in_valid; pix_in = in_pixel; sof_in = in_sof; en_in = en;
`ifdef CAMBUS_TX_TESTPAT_EN
    tp_in = testpat_sel;
`else
    tp_in = 1'b0;
`endif
    @(posedge clk); #1;
    e_uf = 0; e_se = 0;
    if (ph == 0) begin
      if (!m_run) begin
        if (en_in) begin m_run = 1; m_t = 0; m_pops = 0; m_tp = tp_in; end
      end else if (m_t == FRAME_LEN - 1) begin
        m_fc++;
        if (en_in) begin m_t = 0; m_pops = 0; m_tp = tp_in; end
        else m_run = 0;
      end else begin
        m_t++;
      end
      e_pix = '0;
      if (rdy) begin
        if (valid_in) begin
          e_pix = pix_in; e_se = (sof_in != first); src_val++; m_pops++;
        end else begin
          e_uf = 1;
        end
      end else if (m_run && m_tp && is_vis(m_t)) begin
        e_pix = 12'((h - 2) + (v - 1) + int'(m_fc[7:0]));
      end
    end
    m_cyc++;
    if (underflow === 1'b1) uf_seen++;
    if (sof_err === 1'b1) se_seen++;
    check("cam_clk", cam_clk, ((m_cyc % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0);
    check("hsync", cam_hsync, (m_run && (m_t % H_TOTAL) < HSYNC_LEN) ? 1 : 0);
    check("vsync", cam_vsync, (m_run && (m_t / H_TOTAL) < VSYNC_LEN) ? 1 : 0);
    check("pixel", cam_pixel, e_pix);
    check("underflow", underflow, e_uf);
    check("sof_err", sof_err, e_se);
    check("frame_count", frame_count, m_fc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_frame_end();
    logic [15:0] start;
    start = m_fc;
    for (int i = 0; i < 2 * FRAME_CLK && m_fc == start; i++) step();
  endtask

  task automatic start_and_measure(input string tag);
    int lat;
    lat = 0;
    en  = 1'b1;
    do begin step(); lat++; end while (cam_hsync !== 1'b1 && lat < 4 * CLK_DIV);
    check(tag, (lat <= CLK_DIV + 1) ? 1 : 0, 1);
    check({tag, "_vs"}, cam_vsync, 1);
  endtask

  task automatic clear_counts();
    pop_seen = 0; uf_seen = 0; se_seen = 0;
  endtask

  initial begin
    valid_mode = 0; sof_mode = 0; src_val = 12'h100;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    #1 rst_n = 1'b1;

    // idle with en low: bus quiet, divider running
    run(12);

    // clean frame, always-valid ramp source
    start_and_measure("start_latency");
    clear_counts();
    run_to_frame_end();
    check("pops_per_frame", pop_seen, H_ACTIVE * V_ACTIVE);
    check("no_underflow", uf_seen, 0);
    check("no_sof_err", se_seen, 0);

    // random source stalls
    valid_mode = 1;
    run_to_frame_end();

    // directed stall on line 3, k=2..4
    valid_mode = 2;
    clear_counts();
    run_to_frame_end();
    check("stall_underflows", uf_seen, 3);
    check("stall_pops", pop_seen, H_ACTIVE * V_ACTIVE - 3);

    // misplaced sof: present at pop 5, absent at frame start
    valid_mode = 0;
    sof_mode = 1;
    clear_counts();
    run_to_frame_end();
    check("sof_err_pulses", se_seen, 2);
    sof_mode = 0;

    // en drop mid-frame completes the frame then idles
    for (int i = 0; i < 2 * FRAME_CLK && (m_t / H_TOTAL) != 3; i++) step();
    en = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && m_run; i++) step();
    run(20);
    check("idle_hsync", cam_hsync, 0);
    start_and_measure("restart_latency");
    run(30);

    // async reset mid-line on a non-tick cycle
    for (int i = 0; i < CLK_DIV && (m_cyc % CLK_DIV) != 2; i++) step();
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    model_reset();
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(80);

`ifdef CAMBUS_TX_TESTPAT_EN
    testpat_sel = 1'b1;
    run_to_frame_end();
    clear_counts();
    run_to_frame_end();
    run_to_frame_end();
    check("tp_no_pops", pop_seen, 0);
    testpat_sel = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
